// File: rtl/accel_pkg.sv
// Shared constants, FSM state type and nibble helper for the Zorro II AUTOCONFIG engine.
package accel_pkg;

    localparam logic [7:0] AC_WINDOW     = 8'hE8;

    // Register offsets are ADDRESS[7:1], i.e. byte offset divided by two.
    localparam logic [6:0] AC_ER_TYPE    = 7'h00;
    localparam logic [6:0] AC_ER_TYPE_LO = 7'h01;
    localparam logic [6:0] AC_PRODUCT    = 7'h02;
    localparam logic [6:0] AC_PRODUCT_LO = 7'h03;
    localparam logic [6:0] AC_BASE_HI    = 7'h24;
    localparam logic [6:0] AC_BASE_LO    = 7'h25;
    localparam logic [6:0] AC_SHUTUP     = 7'h26;

    typedef enum logic [1:0] {
        AC_IDLE,
        AC_ACCEPT,
        AC_WAIT,
        AC_ACK
    } ac_state_e;

    // Nibble k of a 32-bit word, k=0 being the most significant nibble.
    function automatic logic [3:0] nib_sel32(input logic [31:0] v, input logic [2:0] k);
        logic [31:0] s;
        s = v << {k, 2'b00};
        return s[31:28];
    endfunction

endpackage

// File: rtl/ac_rom_mux.sv
// Combinational AUTOCONFIG parameter ROM: returns the (possibly inverted) nibble
// for the board selected by idx at register offset 'offset'.
module ac_rom_mux
    import accel_pkg::*;
#(
    parameter int                        NUM_BOARDS = 3,
    parameter int                        IDX_W      = $clog2(NUM_BOARDS + 1),
    parameter logic [15:0]               MFG_ID     = 16'h07DB,
    parameter logic [8*NUM_BOARDS-1:0]   ER_TYPE    = {8'hE0, 8'hC0, 8'hC0},
    parameter logic [8*NUM_BOARDS-1:0]   ER_PRODUCT = {8'h58, 8'h59, 8'h5A},
    parameter logic [31:0]               SERIAL     = 32'h0
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [6:0]       offset,
    output logic [3:0]       nibble
);

    logic [7:0] type_b;
    logic [7:0] prod_b;
    logic [3:0] raw;
    logic [2:0] ser_k;

    always_comb begin
        type_b = ER_TYPE[7:0];
        prod_b = ER_PRODUCT[7:0];
        for (int i = 1; i < NUM_BOARDS; i++) begin
            if (idx == IDX_W'(i)) begin
                type_b = ER_TYPE[8*i +: 8];
                prod_b = ER_PRODUCT[8*i +: 8];
            end
        end
    end

    // Serial occupies offsets 12..19; adding 4 to the low three bits maps them onto 0..7.
    assign ser_k = offset[2:0] + 3'd4;

    always_comb begin
        raw = 4'h0;
        case (offset)
            AC_ER_TYPE:    raw = type_b[7:4];
            AC_ER_TYPE_LO: raw = type_b[3:0];
            AC_PRODUCT:    raw = prod_b[7:4];
            AC_PRODUCT_LO: raw = prod_b[3:0];
            7'h08, 7'h09, 7'h0A, 7'h0B:
                raw = nib_sel32({MFG_ID, 16'h0000}, {1'b0, offset[1:0]});
            7'h0C, 7'h0D, 7'h0E, 7'h0F, 7'h10, 7'h11, 7'h12, 7'h13:
                raw = nib_sel32(SERIAL, ser_k);
            default:       raw = 4'h0;
        endcase
        nibble = (offset == AC_ER_TYPE || offset == AC_ER_TYPE_LO) ? raw : ~raw;
    end

endmodule

// File: rtl/autoconfig_chain.sv
// Zorro II AUTOCONFIG engine: presents NUM_BOARDS logical boards in turn in the $E8xxxx
// window, serves ROM nibbles, captures base addresses and generates its own DTACK.
module autoconfig_chain
    import accel_pkg::*;
#(
    parameter int                        NUM_BOARDS = 3,
    parameter int                        DTACK_WAIT = 1,
    parameter logic [15:0]               MFG_ID     = 16'h07DB,
    parameter logic [8*NUM_BOARDS-1:0]   ER_TYPE    = {8'hE0, 8'hC0, 8'hC0},
    parameter logic [8*NUM_BOARDS-1:0]   ER_PRODUCT = {8'h58, 8'h59, 8'h5A},
    parameter logic [31:0]               SERIAL     = 32'h0
) (
    input  logic                      CPU_CLK,
    input  logic                      RESET,
    input  logic                      CPU_AS,
    input  logic                      UDS,
    input  logic                      LDS,
    input  logic                      RW,
    input  logic [23:1]               ADDRESS,
    input  logic [3:0]                DATA_IN,
    output logic [3:0]                DATA_OUT,
    output logic                      DATA_OE,
    output logic                      AC_DTACK,
    output logic [8*NUM_BOARDS-1:0]   BASE,
    output logic [NUM_BOARDS-1:0]     CONFIGURED,
    output logic [NUM_BOARDS-1:0]     SHUTUP,
    output logic                      ALL_DONE
);

    localparam int               IDX_W     = $clog2(NUM_BOARDS + 1);
    localparam logic [IDX_W-1:0] IDX_DONE  = IDX_W'(NUM_BOARDS);
    localparam logic [2:0]       WAIT_LOAD = (DTACK_WAIT > 0) ? 3'(DTACK_WAIT - 1) : 3'd0;

    // Bus handshake: a cycle starts when synchronised AS and DS are both low on a hit;
    // AC_DTACK stays low from ACK until synchronised AS returns high, and an AS release
    // before ACK aborts the cycle without any DTACK.
    logic as_s1, as_s2, ds_s1, ds_s2;
    ac_state_e state, state_nx;
    logic [2:0]       cnt;
    logic [IDX_W-1:0] idx;
    logic [3:0]       lo_nib;
    logic [6:0]       off_q;
    logic [3:0]       din_q;
    logic             rw_q;
    logic [3:0]       data_out_q;
    logic             data_oe_q;
    logic [7:0]       base_r [NUM_BOARDS];
    logic [NUM_BOARDS-1:0] conf_q, shut_q;
    logic [3:0]       rom_nib;
    logic             all_done, hit, strobe, go;

    wire unused_addr = &{1'b0, ADDRESS[15:8]};

    always_ff @(posedge CPU_CLK or negedge RESET) begin
        if (!RESET) begin
            as_s1 <= 1'b1;
            as_s2 <= 1'b1;
            ds_s1 <= 1'b1;
            ds_s2 <= 1'b1;
        end else begin
            as_s1 <= CPU_AS;
            as_s2 <= as_s1;
            ds_s1 <= UDS & LDS;
            ds_s2 <= ds_s1;
        end
    end

    assign all_done = (idx == IDX_DONE);
    assign hit      = (ADDRESS[23:16] == AC_WINDOW) && !all_done;
    assign strobe   = !as_s2 && !ds_s2;
    assign go       = (state == AC_IDLE) && strobe && hit;

    ac_rom_mux #(
        .NUM_BOARDS (NUM_BOARDS),
        .IDX_W      (IDX_W),
        .MFG_ID     (MFG_ID),
        .ER_TYPE    (ER_TYPE),
        .ER_PRODUCT (ER_PRODUCT),
        .SERIAL     (SERIAL)
    ) u_rom (
        .idx    (idx),
        .offset (ADDRESS[7:1]),
        .nibble (rom_nib)
    );

    always_comb begin
        state_nx = state;
        case (state)
            AC_IDLE:   if (go) state_nx = AC_ACCEPT;
            AC_ACCEPT: begin
                if (as_s2)                state_nx = AC_IDLE;
                else if (DTACK_WAIT == 0) state_nx = AC_ACK;
                else                      state_nx = AC_WAIT;
            end
            AC_WAIT: begin
                if (as_s2)            state_nx = AC_IDLE;
                else if (cnt == 3'd0) state_nx = AC_ACK;
            end
            AC_ACK:    if (as_s2) state_nx = AC_IDLE;
            default:   state_nx = AC_IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= AC_IDLE;
            cnt        <= 3'd0;
            idx        <= '0;
            lo_nib     <= 4'h0;
            off_q      <= 7'h00;
            din_q      <= 4'h0;
            rw_q       <= 1'b1;
            data_out_q <= 4'h0;
            data_oe_q  <= 1'b0;
            conf_q     <= '0;
            shut_q     <= '0;
            for (int b = 0; b < NUM_BOARDS; b++) base_r[b] <= 8'h00;
        end else begin
            state <= state_nx;

            if (go) begin
                off_q      <= ADDRESS[7:1];
                din_q      <= DATA_IN;
                rw_q       <= RW;
                data_out_q <= rom_nib;
                data_oe_q  <= RW;
            end else if (state_nx == AC_IDLE) begin
                data_oe_q  <= 1'b0;
            end

            if (state == AC_ACCEPT)
                cnt <= WAIT_LOAD;
            else if (state == AC_WAIT && cnt != 3'd0)
                cnt <= cnt - 3'd1;

            // ACCEPT lasts exactly one cycle per strobe, so each write commits once.
            if (state == AC_ACCEPT && !rw_q && !all_done) begin
                case (off_q)
                    AC_BASE_LO: lo_nib <= din_q;
                    AC_BASE_HI: begin
                        for (int b = 0; b < NUM_BOARDS; b++) begin
                            if (idx == IDX_W'(b)) begin
                                base_r[b] <= {din_q, lo_nib};
                                conf_q[b] <= 1'b1;
                            end
                        end
                        idx <= idx + IDX_W'(1);
                    end
                    AC_SHUTUP: begin
                        for (int b = 0; b < NUM_BOARDS; b++)
                            if (idx == IDX_W'(b)) shut_q[b] <= 1'b1;
                        idx <= idx + IDX_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_BOARDS; g++) begin : g_base
        assign BASE[8*g +: 8] = base_r[g];
    end

    assign DATA_OUT   = data_out_q;
    assign DATA_OE    = data_oe_q;
    assign AC_DTACK   = (state != AC_ACK);
    assign CONFIGURED = conf_q;
    assign SHUTUP     = shut_q;
    assign ALL_DONE   = all_done;

endmodule

// File: tb/tb_autoconfig_chain.sv
// Directed bench for autoconfig_chain: three instances (default chain, single-board
// zero-wait build, long-wait build) share the bus but each has its own address strobe.
module tb_autoconfig_chain;
    import accel_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  as_n = 3'b111;
    logic        uds = 1'b1, lds = 1'b1, rw = 1'b1;
    logic [23:1] addr = '0;
    logic [3:0]  din = 4'h0;

    logic [3:0]  dout [3];
    logic [2:0]  oe, dtk, done;
    logic [23:0] base0, base2;
    logic [7:0]  base1;
    logic [2:0]  conf0, shut0, conf2, shut2;
    logic [0:0]  conf1, shut1;

    int n_checks = 0;
    int n_fail = 0;
    int sel = 0;
    logic cur_rw = 1'b1;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    autoconfig_chain #(.NUM_BOARDS(3), .DTACK_WAIT(1), .ER_TYPE(24'hC0C0E0),
                       .ER_PRODUCT(24'h58595A), .SERIAL(32'h12345678)) u_dut0 (
        .CPU_CLK(clk), .RESET(rst_n), .CPU_AS(as_n[0]), .UDS(uds), .LDS(lds), .RW(rw),
        .ADDRESS(addr), .DATA_IN(din), .DATA_OUT(dout[0]), .DATA_OE(oe[0]),
        .AC_DTACK(dtk[0]), .BASE(base0), .CONFIGURED(conf0), .SHUTUP(shut0), .ALL_DONE(done[0]));

    autoconfig_chain #(.NUM_BOARDS(1), .DTACK_WAIT(0), .ER_TYPE(8'hE0),
                       .ER_PRODUCT(8'h5A), .SERIAL(32'h0)) u_dut1 (
        .CPU_CLK(clk), .RESET(rst_n), .CPU_AS(as_n[1]), .UDS(uds), .LDS(lds), .RW(rw),
        .ADDRESS(addr), .DATA_IN(din), .DATA_OUT(dout[1]), .DATA_OE(oe[1]),
        .AC_DTACK(dtk[1]), .BASE(base1), .CONFIGURED(conf1), .SHUTUP(shut1), .ALL_DONE(done[1]));

    autoconfig_chain #(.NUM_BOARDS(3), .DTACK_WAIT(3), .ER_TYPE(24'hC0C0E0),
                       .ER_PRODUCT(24'h58595A), .SERIAL(32'h0)) u_dut2 (
        .CPU_CLK(clk), .RESET(rst_n), .CPU_AS(as_n[2]), .UDS(uds), .LDS(lds), .RW(rw),
        .ADDRESS(addr), .DATA_IN(din), .DATA_OUT(dout[2]), .DATA_OE(oe[2]),
        .AC_DTACK(dtk[2]), .BASE(base2), .CONFIGURED(conf2), .SHUTUP(shut2), .ALL_DONE(done[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DTACK falling edge on a read pops one expected nibble.
    logic prev_dtk = 1'b1;
    logic [3:0] e_nib;
    always @(posedge clk) begin
        #1;
        if (prev_dtk && !dtk[sel] && cur_rw) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_dtack", 32'd1, 32'd0);
            end else begin
                e_nib = exp_q.pop_front();
                chk("sb_data_out", {28'h0, dout[sel]}, {28'h0, e_nib});
                chk("sb_data_oe", {31'h0, oe[sel]}, 32'd1);
            end
        end
        prev_dtk = dtk[sel];
    end

    task automatic bus(input int s, input logic rd, input logic [23:0] a, input logic [3:0] d,
                       input logic ack, input int exp_lat);
        int n;
        logic seen, oe_seen;
        @(negedge clk);
        sel = s; cur_rw = rd; rw = rd; addr = a[23:1]; din = d;
        uds = 1'b0; lds = 1'b0; as_n[s] = 1'b0;
        n = 0; seen = 1'b0; oe_seen = 1'b0;
        @(posedge clk);
        while (n < 20 && !seen) begin
            @(posedge clk); #1;
            n++;
            oe_seen |= oe[s];
            if (!dtk[s]) seen = 1'b1;
        end
        if (ack) begin
            chk("dtack_seen", {31'h0, seen}, 32'd1);
            if (exp_lat >= 0) chk("dtack_latency", n, exp_lat);
        end else begin
            chk("no_dtack", {31'h0, seen}, 32'd0);
            chk("no_drive", {31'h0, oe_seen}, 32'd0);
        end
        @(negedge clk);
        as_n[s] = 1'b1; uds = 1'b1; lds = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (n < 10 && !(dtk[s] && !oe[s]));
        chk("cycle_release", {30'h0, dtk[s], oe[s]}, 32'd2);
    endtask

    task automatic rd(input int s, input logic [23:0] a, input logic [3:0] e, input int lat);
        exp_q.push_back(e);
        bus(s, 1'b1, a, 4'h0, 1'b1, lat);
    endtask

    task automatic wr(input int s, input logic [23:0] a, input logic [3:0] d);
        bus(s, 1'b0, a, d, 1'b1, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", {28'h0, dout[0]}, 32'h0);
        chk("rst_oe_dtack", {29'h0, oe[0], dtk[0], done[0]}, 32'h2);
        chk("rst_base", base0, 32'h0);
        chk("rst_conf_shut", {conf0, shut0}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Board 0 ROM: type E0, product 5A, MFG 07DB, serial 12345678
        rd(0, 24'hE80000, 4'hE, 4);
        rd(0, 24'hE80002, 4'h0, 4);
        rd(0, 24'hE80004, 4'hA, 4);
        rd(0, 24'hE80006, 4'h5, -1);
        rd(0, 24'hE80010, 4'hF, -1);
        rd(0, 24'hE80016, 4'h4, -1);
        rd(0, 24'hE80018, 4'hE, -1);
        rd(0, 24'hE80026, 4'h7, -1);
        rd(0, 24'hE80008, 4'hF, -1);
        rd(0, 24'hE80040, 4'hF, -1);
        bus(0, 1'b1, 24'hF00000, 4'h0, 1'b0, -1);
        wr(0, 24'hE80040, 4'h9);
        chk("ignored_write", {conf0, shut0}, 32'h0);

        wr(0, 24'hE8004A, 4'h0);
        wr(0, 24'hE80048, 4'h2);
        chk("base_b0", base0, 32'h000020);
        chk("conf_b0", conf0, 32'h1);
        rd(0, 24'hE80000, 4'hC, -1);
        rd(0, 24'hE80006, 4'h6, -1);

        wr(0, 24'hE8004C, 4'h0);
        chk("shut_b1", {conf0, shut0}, 32'b001_010);
        chk("not_done", done[0], 32'd0);
        wr(0, 24'hE8004A, 4'h5);
        wr(0, 24'hE80048, 4'h8);
        chk("base_b2", base0, 32'h850020);
        chk("conf_b2", {conf0, shut0, done[0]}, 32'b101_010_1);
        bus(0, 1'b1, 24'hE80000, 4'h0, 1'b0, -1);

        // Single-board zero-wait build
        rd(1, 24'hE80000, 4'hE, 3);
        wr(1, 24'hE80048, 4'h4);
        chk("nb1_base", base1, 32'h40);
        chk("nb1_done", {conf1, done[1]}, 32'b11);
        bus(1, 1'b1, 24'hE80000, 4'h0, 1'b0, -1);

        // Aborted write: AS negated one cycle after ACCEPT; the write still stands
        @(negedge clk);
        sel = 2; cur_rw = 1'b0; rw = 1'b0; addr = 23'(24'hE8004A >> 1); din = 4'h7;
        uds = 1'b0; lds = 1'b0; as_n[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("abort_accept", 32'(u_dut2.state), 32'(AC_ACCEPT));
        @(posedge clk);
        @(negedge clk); as_n[2] = 1'b1; uds = 1'b1; lds = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!dtk[2]) seen = 1'b1;
        end
        chk("abort_no_dtack", {31'h0, seen}, 32'd0);
        chk("abort_idle", 32'(u_dut2.state), 32'(AC_IDLE));
        wr(2, 24'hE80048, 4'h3);
        chk("abort_write_stands", base2, 32'h000037);
        wr(2, 24'hE80048, 4'h1);
        chk("two_boards", {base2, conf2}, {24'h001737, 3'b011});

        // Reset asserted while the long-wait build sits in WAIT
        @(negedge clk);
        sel = 2; cur_rw = 1'b1; rw = 1'b1; addr = '0; addr[23:16] = 8'hE8;
        uds = 1'b0; lds = 1'b0; as_n[2] = 1'b0;
        n = 0; seen = 1'b0;
        while (n < 10 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (u_dut2.state == AC_WAIT) seen = 1'b1;
        end
        chk("reached_wait", {31'h0, seen}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", {27'h0, dout[2], oe[2]}, 32'h0);
        chk("arst_dtack_done", {30'h0, dtk[2], done[2]}, 32'h2);
        chk("arst_regs", {base2, conf2, shut2}, 32'h0);
        chk("arst_idx", 32'(u_dut2.idx), 32'd0);
        chk("arst_state", 32'(u_dut2.state), 32'(AC_IDLE));
        chk("arst_dut0_done", {29'h0, done[0], conf0 == 3'b000, base0 == 24'h0}, 32'h3);
        @(negedge clk);
        as_n[2] = 1'b1; uds = 1'b1; lds = 1'b1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        chk("sb_queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
